int_mac_pe_os: RTL and testbench
================================

// Module: int_mac_pe_os
// PURPOSE
// - Output-stationary signed integer MAC processing element for the systolic array.
// - Forwards row/col operands with valid tags one cycle east/south.
// - Accumulates products in a wide accumulator.
// - Unloads results through a per-column drain chain, with optional saturation.
// - Accumulation of the next tile overlaps with draining of the previous tile.
// PARAMETERS
// DATA_WIDTH  16  operand width (signed)
// ACC_WIDTH   40  accumulator width (signed), must be >= 2*DATA_WIDTH
// OUT_WIDTH   16  drained result width (signed), must be <= ACC_WIDTH
// ROW_IDX     0   PE row position; number of upstream PEs whose results pass through this PE
// PORTS
// clk             in   1           clock
// rstn            in   1           reset, synchronous, active-low
// in_row          in   DATA_WIDTH  row operand from west
// in_row_valid    in   1           in_row qualifier
// in_col          in   DATA_WIDTH  column operand from north
// in_col_valid    in   1           in_col qualifier
// sat_en          in   1           1: saturate to OUT_WIDTH on drain; 0: truncate (wrap)
// drain_start     in   1           single-cycle pulse: emit own result, begin forwarding
// drain_in        in   OUT_WIDTH   drain word from PE above
// drain_in_valid  in   1           drain_in qualifier
// out_row         out  DATA_WIDTH  registered in_row to east
// out_row_valid   out  1           registered in_row_valid
// out_col         out  DATA_WIDTH  registered in_col to south
// out_col_valid   out  1           registered in_col_valid
// drain_out       out  OUT_WIDTH   drain word to PE below
// drain_out_valid out  1           drain_out qualifier
// acc_ovf         out  1           sticky: accumulator signed overflow since last drain
// busy            out  1           high while in FWD state
// BEHAVIOUR
// - Reset (rstn=0 at clk edge, any state):
//   - All outputs, acc, fwd_cnt and acc_ovf go to 0; state goes to ACC.
//   - A reset mid-drain discards any in-flight words.
// - Forwarding: every cycle, out_row_valid<=in_row_valid and out_col_valid<=in_col_valid.
//   - out_row/out_col load in_row/in_col only when the matching valid is 1; otherwise they hold.
//   - Latency is 1 cycle.
// - MAC:
//   - fire = in_row_valid & in_col_valid.
//   - prod = in_row*in_col, full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH.
//   - On fire, acc <= acc+prod, wrapping mod 2^ACC_WIDTH.
//   - acc_ovf is set when the operands have the same sign and the sum sign differs.
//   - MAC runs in both states; it is never stalled by draining.
// - Result: res = acc+(fire?prod:0), computed the same cycle.
//   - sat_en=1: clamp res to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//   - sat_en=1 and acc_ovf=1 (including overflow this cycle): clamp toward the sign of the
//     last operand before the wrap, i.e. max if positive overflow, min if negative.
//   - sat_en=0: res[OUT_WIDTH-1:0].
// - State machine, ACC:
//   - On drain_start: drain_out<=res, drain_out_valid<=1, acc<=0, acc_ovf<=0.
//   - The same-cycle fire product is included in res, not in the new acc.
//   - fwd_cnt<=0; go to FWD if ROW_IDX>0, else stay in ACC.
//   - Otherwise drain_out_valid<=0.
// - State machine, FWD:
//   - drain_out<=drain_in and drain_out_valid<=drain_in_valid every cycle; drain_out holds
//     when not valid.
//   - Each valid word increments fwd_cnt.
//   - When the ROW_IDX-th valid word is forwarded, return to ACC the next cycle.
//   - drain_start in FWD is ignored: no result capture, acc untouched.
//   - drain_in_valid in ACC is dropped.
// - busy = (state==FWD). The words of one column therefore leave the bottom PE contiguously,
//   bottom row first.
// TESTING
// - Reset, then row=3 valid and col=-4 valid for 4 cycles
//   -> acc=-48, out_row=3/out_col=-4 one cycle later with valid=1.
// - ROW_IDX=0, drain_start on the same cycle as a 5th fire(3,-4)
//   -> drain_out=-60 valid 1 cycle, acc=0; the next fire(2,2) gives acc=4.
// - sat_en=1, acc=40000, OUT_WIDTH=16, drain -> drain_out=32767.
//   - sat_en=0, same acc -> drain_out=-25536.
// - Drive 0x7FFF*0x7FFF for 600 cycles with ACC_WIDTH=40
//   -> acc_ovf=1 by ~cycle 512; sat_en=1 drain -> drain_out=32767 and acc_ovf cleared.
// - ROW_IDX=2, drain_start, then drain_in 11, (gap), 22
//   -> drain_out sequence own, 11, 22; busy high until the cycle after 22; a second
//      drain_start while busy is ignored.
// - rstn low mid-FWD with fire active -> all outputs 0, state ACC, the next drain_start
//   emits only the post-reset result.

Source files
------------

// File: rtl/int_mac_pe_os.sv
// int_mac_pe_os: output-stationary signed MAC PE with operand forwarding and a saturating drain chain
module int_mac_pe_os #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int ROW_IDX    = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] in_row,
  input  logic                  in_row_valid,
  input  logic [DATA_WIDTH-1:0] in_col,
  input  logic                  in_col_valid,
  input  logic                  sat_en,
  input  logic                  drain_start,
  input  logic [OUT_WIDTH-1:0]  drain_in,
  input  logic                  drain_in_valid,
  output logic [DATA_WIDTH-1:0] out_row,
  output logic                  out_row_valid,
  output logic [DATA_WIDTH-1:0] out_col,
  output logic                  out_col_valid,
  output logic [OUT_WIDTH-1:0]  drain_out,
  output logic                  drain_out_valid,
  output logic                  acc_ovf,
  output logic                  busy
);
  localparam int CW = $clog2(ROW_IDX + 2);
  localparam logic signed [ACC_WIDTH-1:0] OMAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OMIN = ~OMAX;
  localparam logic [OUT_WIDTH-1:0] OMAX_W = OMAX[OUT_WIDTH-1:0];
  localparam logic [OUT_WIDTH-1:0] OMIN_W = OMIN[OUT_WIDTH-1:0];
  typedef enum logic {ACC, FWD} state_t;
  state_t state_q, state_d;
  logic signed [2*DATA_WIDTH-1:0] mul;
  logic signed [ACC_WIDTH-1:0] acc_q, prod, sum;
  logic [CW-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [OUT_WIDTH-1:0] word, drain_d;
  logic ovf_neg_q, fire, ovf_now, ovf_any, neg_dir, drain_take, last_word, drain_v_d;
  assign fire       = in_row_valid & in_col_valid;
  assign mul        = $signed(in_row) * $signed(in_col);
  assign prod       = ACC_WIDTH'(mul);
  assign sum        = acc_q + (fire ? prod : '0);
  assign ovf_now    = fire & (acc_q[ACC_WIDTH-1] == prod[ACC_WIDTH-1]) & (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  assign ovf_any    = acc_ovf | ovf_now;
  assign neg_dir    = ovf_now ? acc_q[ACC_WIDTH-1] : ovf_neg_q;
  assign drain_take = (state_q == ACC) & drain_start;
  assign last_word  = drain_in_valid & (fwd_cnt_q == CW'(ROW_IDX - 1));
  assign word = !sat_en ? sum[OUT_WIDTH-1:0] :
                ovf_any ? (neg_dir ? OMIN_W : OMAX_W) :
                sum > OMAX ? OMAX_W :
                sum < OMIN ? OMIN_W : sum[OUT_WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= ACC;
      fwd_cnt_q       <= '0;
      acc_q           <= '0;
      acc_ovf         <= 1'b0;
      ovf_neg_q       <= 1'b0;
      out_row         <= '0;
      out_row_valid   <= 1'b0;
      out_col         <= '0;
      out_col_valid   <= 1'b0;
      drain_out       <= '0;
      drain_out_valid <= 1'b0;
    end else begin
      state_q         <= state_d;
      fwd_cnt_q       <= fwd_cnt_d;
      acc_q           <= drain_take ? '0 : sum;
      acc_ovf         <= !drain_take & ovf_any;
      ovf_neg_q       <= !drain_take & neg_dir;
      out_row         <= in_row_valid ? in_row : out_row;
      out_row_valid   <= in_row_valid;
      out_col         <= in_col_valid ? in_col : out_col;
      out_col_valid   <= in_col_valid;
      drain_out       <= drain_d;
      drain_out_valid <= drain_v_d;
    end
  end
  always_comb begin
    state_d   = (state_q == ACC) ? ((drain_take && (ROW_IDX > 0)) ? FWD : ACC) : (last_word ? ACC : FWD);
    fwd_cnt_d = drain_take ? '0 : ((state_q == FWD) && drain_in_valid) ? fwd_cnt_q + 1'b1 : fwd_cnt_q;
  end
  always_comb begin
    busy      = (state_q == FWD);
    drain_d   = drain_take ? word : (busy && drain_in_valid) ? drain_in : drain_out;
    drain_v_d = busy ? drain_in_valid : drain_take;
  end
endmodule

// File: tb/tb_int_mac_pe_os.sv
// tb_int_mac_pe_os: scoreboard bench for int_mac_pe_os with an arithmetic reference model
module tb_int_mac_pe_os;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn = 1'b0, in_row_valid = 1'b0, in_col_valid = 1'b0, sat_en = 1'b0, drain_start = 1'b0, drain_in_valid = 1'b0;
  logic [15:0] in_row = '0, in_col = '0, drain_in = '0;
  logic [15:0] o0_row, o0_col, o0_d, o2_row, o2_col, o2_d;
  logic o0_rv, o0_cv, o0_dv, o0_ovf, o0_busy, o2_rv, o2_cv, o2_dv, o2_ovf, o2_busy;
  int errors = 0, checks = 0;
  logic [15:0] row_q[$], col_q[$], d0_q[$], d2_q[$];
  longint macc[2];
  bit movf[2], mneg[2], busy_e[2], ovf_e[2];
  int mleft[2];
  int_mac_pe_os #(.ROW_IDX(0)) u0 (
    .clk(clk), .rstn(rstn), .in_row(in_row), .in_row_valid(in_row_valid), .in_col(in_col),
    .in_col_valid(in_col_valid), .sat_en(sat_en), .drain_start(drain_start), .drain_in(16'h0),
    .drain_in_valid(1'b0), .out_row(o0_row), .out_row_valid(o0_rv), .out_col(o0_col),
    .out_col_valid(o0_cv), .drain_out(o0_d), .drain_out_valid(o0_dv), .acc_ovf(o0_ovf), .busy(o0_busy)
  );
  int_mac_pe_os #(.ROW_IDX(2)) u2 (
    .clk(clk), .rstn(rstn), .in_row(in_row), .in_row_valid(in_row_valid), .in_col(in_col),
    .in_col_valid(in_col_valid), .sat_en(sat_en), .drain_start(drain_start), .drain_in(drain_in),
    .drain_in_valid(drain_in_valid), .out_row(o2_row), .out_row_valid(o2_rv), .out_col(o2_col),
    .out_col_valid(o2_cv), .drain_out(o2_d), .drain_out_valid(o2_dv), .acc_ovf(o2_ovf), .busy(o2_busy)
  );
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic extra(input string nm, input longint act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected no word", nm, act);
  endtask
  always @(negedge clk) begin
    if (o2_rv) begin
      if (row_q.size() == 0) extra("out_row", longint'($signed(o2_row)));
      else chk("out_row", longint'($signed(o2_row)), longint'($signed(row_q.pop_front())));
    end
    if (o2_cv) begin
      if (col_q.size() == 0) extra("out_col", longint'($signed(o2_col)));
      else chk("out_col", longint'($signed(o2_col)), longint'($signed(col_q.pop_front())));
    end
    if (o0_dv) begin
      if (d0_q.size() == 0) extra("drain0", longint'($signed(o0_d)));
      else chk("drain0", longint'($signed(o0_d)), longint'($signed(d0_q.pop_front())));
    end
    if (o2_dv) begin
      if (d2_q.size() == 0) extra("drain2", longint'($signed(o2_d)));
      else chk("drain2", longint'($signed(o2_d)), longint'($signed(d2_q.pop_front())));
    end
  end
  function automatic longint wrap40(input longint x);
    return (x <<< 24) >>> 24;
  endfunction
  task automatic step(input bit r, input bit rv, input logic [15:0] rd, input bit cv, input logic [15:0] cd,
                      input bit ds, input bit s, input bit dv, input logic [15:0] dd);
    longint p, t, w;
    bit on, ng, any;
    logic [15:0] wd;
    @(negedge clk);
    #1;
    chk("busy2", longint'(o2_busy), longint'(busy_e[1]));
    chk("ovf0", longint'(o0_ovf), longint'(ovf_e[0]));
    chk("ovf2", longint'(o2_ovf), longint'(ovf_e[1]));
    rstn = r; in_row_valid = rv; in_row = rd; in_col_valid = cv; in_col = cd;
    drain_start = ds; sat_en = s; drain_in_valid = dv; drain_in = dd;
    if (!r) begin
      for (int k = 0; k < 2; k++) begin
        macc[k] = 0; movf[k] = 0; mneg[k] = 0; mleft[k] = 0; busy_e[k] = 0; ovf_e[k] = 0;
      end
      row_q.delete(); col_q.delete(); d0_q.delete(); d2_q.delete();
      return;
    end
    p = (rv && cv) ? longint'($signed(rd)) * longint'($signed(cd)) : 0;
    if (rv) row_q.push_back(rd);
    if (cv) col_q.push_back(cd);
    for (int k = 0; k < 2; k++) begin
      t = macc[k] + p;
      w = wrap40(t);
      on = (t != w);
      ng = on ? (t < 0) : mneg[k];
      any = movf[k] | on;
      if (mleft[k] == 0 && ds) begin
        if (!s) wd = w[15:0];
        else if (any) wd = ng ? 16'h8000 : 16'h7fff;
        else if (w > 32767) wd = 16'h7fff;
        else if (w < -32768) wd = 16'h8000;
        else wd = w[15:0];
        if (k == 0) d0_q.push_back(wd); else d2_q.push_back(wd);
        macc[k] = 0; movf[k] = 0; mneg[k] = 0; mleft[k] = (k == 1) ? 2 : 0;
      end else begin
        if (mleft[k] > 0 && dv) begin
          d2_q.push_back(dd);
          mleft[k]--;
        end
        macc[k] = w; movf[k] = any; mneg[k] = ng;
      end
      busy_e[k] = mleft[k] > 0;
      ovf_e[k] = movf[k];
    end
  endtask
  task automatic rst_chk;
    @(negedge clk);
    #1;
    chk("rst_out_row", longint'(o2_row), 0);
    chk("rst_out_col", longint'(o2_col), 0);
    chk("rst_valids", longint'({o2_rv, o2_cv, o2_dv, o0_dv}), 0);
    chk("rst_drain", longint'({o2_d, o0_d}), 0);
    chk("rst_flags", longint'({o2_busy, o2_ovf, o0_busy, o0_ovf}), 0);
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_chk();
    repeat (4) step(1, 1, 16'd3, 1, -16'sd4, 0, 0, 0, 0);
    step(1, 1, 16'd3, 1, -16'sd4, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 16'd11);
    step(1, 1, 16'd2, 1, 16'd2, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 1, 16'd22);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 16'd200, 1, 16'd200, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 16'd200, 1, 16'd200, 0, 0, 1, 16'd7);
    step(1, 0, 0, 0, 0, 0, 0, 1, 16'd8);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, -16'sd200, 1, 16'd200, 0, 0, 1, 16'h1234);
    step(1, 0, 0, 0, 0, 0, 0, 1, 16'h8001);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 600; i++) step(1, 1, 16'h7fff, 1, 16'h7fff, 0, 0, i < 2, 16'(i + 5));
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 16'd9, 1, 16'd9, 0, 0, 1, 16'd99);
    step(0, 1, 16'd9, 1, 16'd9, 0, 0, 1, 16'd98);
    rst_chk();
    step(1, 1, 16'd5, 1, 16'd6, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 16'd1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 16'd2);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 100)) - 50);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 100)) - 50);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0, b,
           $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 16'($urandom));
    end
    repeat (4) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("queues_drained", longint'(row_q.size() + col_q.size() + d0_q.size() + d2_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
